change_dispenser: RTL and testbench

//  Downstream of the vending controller: takes the change amount the controller reports and

---
 rtl/vend_pkg.sv | 41 ++++
 rtl/change_dispenser_if.sv | 24 ++
 rtl/coin_stock.sv | 55 +++++
 rtl/change_dispenser.sv | 169 ++++++++++++++++
 tb/tb_change_dispenser.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine definitions.
//   denom_t     : coin-hopper denomination codes (00 = no coin)
//   VAL_*       : dollar value of each denomination
//   PRICE_*     : drink prices used by the vending controller
//   state_t     : change_dispenser sequencer states
//   denom_value : maps a denomination code to its dollar value
package vend_pkg;

  typedef enum logic [1:0] {
    DENOM_NONE = 2'b00,
    DENOM_1    = 2'b01,
    DENOM_5    = 2'b10,
    DENOM_10   = 2'b11
  } denom_t;

  localparam logic [3:0] VAL_1  = 4'd1;
  localparam logic [3:0] VAL_5  = 4'd5;
  localparam logic [3:0] VAL_10 = 4'd10;

  localparam logic [31:0] PRICE_WATER = 32'd1;
  localparam logic [31:0] PRICE_COLA  = 32'd3;
  localparam logic [31:0] PRICE_JUICE = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_REQ    = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  function automatic logic [3:0] denom_value(input denom_t d);
    case (d)
      DENOM_1:  return VAL_1;
      DENOM_5:  return VAL_5;
      DENOM_10: return VAL_10;
      default:  return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Handshake bundle of the change dispenser.
//   amount_valid/amount/amount_ready : change amount from the vending controller
//   disp_req/disp_denom/disp_ack     : one-coin request/acknowledge to the hopper
// master: the environment side (controller + hopper); slave: the dispenser.
interface change_dispenser_if #(
  parameter int AMT_W = 32
);
  logic             amount_valid;
  logic [AMT_W-1:0] amount;
  logic             amount_ready;
  logic             disp_req;
  logic [1:0]       disp_denom;
  logic             disp_ack;

  modport master (
    output amount_valid, amount, disp_ack,
    input  amount_ready, disp_req, disp_denom
  );

  modport slave (
    input  amount_valid, amount, disp_ack,
    output amount_ready, disp_req, disp_denom
  );
endinterface

// File: rtl/coin_stock.sv
// Per-denomination coin stock counters for the change dispenser.
//   clk, reset    : clock, asynchronous active-low reset (loads STOCK_INIT)
//   refill        : reload all counters to STOCK_INIT; wins over a same-cycle decrement
//   dec/dec_denom : one coin of dec_denom was dropped
//   avail_1/5/10  : counter of that denomination is nonzero
module coin_stock
  import vend_pkg::*;
#(
  parameter int STOCK_W    = 8,
  parameter int STOCK_INIT = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refill,
  input  logic       dec,
  input  logic [1:0] dec_denom,
  output logic       avail_1,
  output logic       avail_5,
  output logic       avail_10
);

  localparam logic [STOCK_W-1:0] INIT = STOCK_W'(STOCK_INIT);
  localparam logic [STOCK_W-1:0] ONE  = STOCK_W'(1);

  logic [STOCK_W-1:0] cnt_1_r;
  logic [STOCK_W-1:0] cnt_5_r;
  logic [STOCK_W-1:0] cnt_10_r;

  // Stock counters: refill first, otherwise a decrement that saturates at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_1_r  <= INIT;
      cnt_5_r  <= INIT;
      cnt_10_r <= INIT;
    end else if (refill) begin
      cnt_1_r  <= INIT;
      cnt_5_r  <= INIT;
      cnt_10_r <= INIT;
    end else if (dec) begin
      case (dec_denom)
        DENOM_1:  if (cnt_1_r  != '0) cnt_1_r  <= cnt_1_r  - ONE;
        DENOM_5:  if (cnt_5_r  != '0) cnt_5_r  <= cnt_5_r  - ONE;
        DENOM_10: if (cnt_10_r != '0) cnt_10_r <= cnt_10_r - ONE;
        default: begin
          cnt_1_r <= cnt_1_r;
        end
      endcase
    end
  end

  assign avail_1  = (cnt_1_r  != '0);
  assign avail_5  = (cnt_5_r  != '0);
  assign avail_10 = (cnt_10_r != '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy 10/5/1 change dispenser: accepts a change amount, pays it out one
// coin per hopper handshake and reports the unpaid remainder.
//   clk, reset      : clock, asynchronous active-low reset
//   bus (slave)     : amount_valid/amount/amount_ready in, disp_req/disp_denom/disp_ack out
//   refill          : reload coin stock (1-cycle pulse)
//   busy            : transaction in progress
//   done            : 1-cycle pulse at transaction end
//   shortfall       : unpaid remainder of the last transaction, held until next accept
// Build option CHANGE_DISPENSER_STOCK_EN: finite coin stock via coin_stock.
// Without it stock is infinite, refill is ignored and shortfall stays 0.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W      = 32,
  parameter int STOCK_W    = 8,
  parameter int STOCK_INIT = 20,
  parameter int GAP_CYC    = 2
) (
  input  logic              clk,
  input  logic              reset,
  change_dispenser_if.slave bus,
  input  logic              refill,
  output logic              busy,
  output logic              done,
  output logic [AMT_W-1:0]  shortfall
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

  state_t           state_r;
  logic [AMT_W-1:0] remaining_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic             req_r;
  denom_t           denom_r;
  logic             ready_r;
  logic             busy_r;
  logic             done_r;
  logic [AMT_W-1:0] shortfall_r;

  logic             avail_1_s;
  logic             avail_5_s;
  logic             avail_10_s;
  logic             pick_found_s;
  denom_t           pick_denom_s;

`ifdef CHANGE_DISPENSER_STOCK_EN
  logic dec_s;
  // A coin leaves stock on the cycle its acknowledge is sampled.
  assign dec_s = (state_r == ST_REQ) && bus.disp_ack;

  coin_stock #(
    .STOCK_W    (STOCK_W),
    .STOCK_INIT (STOCK_INIT)
  ) u_coin_stock (
    .clk       (clk),
    .reset     (reset),
    .refill    (refill),
    .dec       (dec_s),
    .dec_denom (denom_r),
    .avail_1   (avail_1_s),
    .avail_5   (avail_5_s),
    .avail_10  (avail_10_s)
  );
`else
  logic               unused_refill;
  logic [STOCK_W-1:0] unused_stock;
  assign unused_refill = refill;
  assign unused_stock  = STOCK_W'(STOCK_INIT);
  assign avail_1_s     = 1'b1;
  assign avail_5_s     = 1'b1;
  assign avail_10_s    = 1'b1;
`endif

  // Greedy choice: largest coin that fits the remainder and is in stock.
  always_comb begin
    pick_found_s = 1'b0;
    pick_denom_s = DENOM_NONE;
    if ((remaining_r >= AMT_W'(VAL_10)) && avail_10_s) begin
      pick_found_s = 1'b1;
      pick_denom_s = DENOM_10;
    end else if ((remaining_r >= AMT_W'(VAL_5)) && avail_5_s) begin
      pick_found_s = 1'b1;
      pick_denom_s = DENOM_5;
    end else if ((remaining_r >= AMT_W'(VAL_1)) && avail_1_s) begin
      pick_found_s = 1'b1;
      pick_denom_s = DENOM_1;
    end else begin
      pick_found_s = 1'b0;
      pick_denom_s = DENOM_NONE;
    end
  end

  // Transaction sequencer with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      remaining_r <= '0;
      gap_cnt_r   <= '0;
      req_r       <= 1'b0;
      denom_r     <= DENOM_NONE;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      shortfall_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.amount_valid && ready_r) begin
            remaining_r <= bus.amount;
            shortfall_r <= '0;
            ready_r     <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (pick_found_s) begin
            req_r   <= 1'b1;
            denom_r <= pick_denom_s;
            state_r <= ST_REQ;
          end else begin
            shortfall_r <= remaining_r;
            done_r      <= 1'b1;
            state_r     <= ST_FINISH;
          end
        end
        ST_REQ: begin
          // denom_r is held for the whole handshake; remaining >= coin was checked in SELECT.
          if (bus.disp_ack) begin
            remaining_r <= remaining_r - AMT_W'(denom_value(denom_r));
            req_r       <= 1'b0;
            denom_r     <= DENOM_NONE;
            gap_cnt_r   <= '0;
            state_r     <= (GAP_CYC == 0) ? ST_SELECT : ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_r <= ST_SELECT;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        ST_FINISH: begin
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          req_r   <= 1'b0;
          denom_r <= DENOM_NONE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.amount_ready = ready_r;
  assign bus.disp_req     = req_r;
  assign bus.disp_denom   = denom_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign shortfall        = shortfall_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed testbench for change_dispenser (default GAP_CYC=2).
// With CHANGE_DISPENSER_STOCK_EN defined the DUT is built with STOCK_INIT=2
// so that stock exhaustion and refill priority become visible.
module tb_change_dispenser;

`ifdef CHANGE_DISPENSER_STOCK_EN
  localparam int TB_STOCK_INIT = 2;
`else
  localparam int TB_STOCK_INIT = 20;
`endif
  localparam int TB_GAP = 2;
  localparam logic [1:0] D1  = 2'b01;
  localparam logic [1:0] D5  = 2'b10;
  localparam logic [1:0] D10 = 2'b11;

  logic        clk;
  logic        reset;
  logic        refill;
  logic        busy;
  logic        done;
  logic [31:0] shortfall;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_coins [0:7];
  int exp_n;
  int last_done_cyc;

  change_dispenser_if #(.AMT_W(32)) bus ();

  change_dispenser #(
    .AMT_W      (32),
    .STOCK_W    (8),
    .STOCK_INIT (TB_STOCK_INIT),
    .GAP_CYC    (TB_GAP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .refill    (refill),
    .busy      (busy),
    .done      (done),
    .shortfall (shortfall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input int n, input logic [1:0] c0, input logic [1:0] c1,
                         input logic [1:0] c2, input logic [1:0] c3, input logic [1:0] c4);
    exp_n = n;
    exp_coins[0] = c0; exp_coins[1] = c1; exp_coins[2] = c2;
    exp_coins[3] = c3; exp_coins[4] = c4;
    exp_coins[5] = 2'b00; exp_coins[6] = 2'b00; exp_coins[7] = 2'b00;
  endtask

  task automatic pulse_refill();
    @(negedge clk);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
  endtask

  // One full transaction: offer amt, answer every request (first one after
  // delay0 extra cycles, optionally with a refill on that ack), check coins,
  // spacing between requests, shortfall and the return to idle.
  task automatic pay(input string tag, input logic [31:0] amt, input int delay0,
                     input bit refill_at_ack, input logic [31:0] exp_sf);
    int cyc, idx, held, low_run;
    bit done_seen;
    logic [1:0] cur_denom;
    @(negedge clk);
    check($sformatf("%s_ready", tag), bus.amount_ready, 1);
    bus.amount_valid = 1'b1;
    bus.amount = amt;
    @(negedge clk);
    bus.amount_valid = 1'b0;
    bus.amount = 32'd0;
    check($sformatf("%s_busy", tag), {busy, bus.amount_ready}, 2'b10);
    idx = 0; held = 0; low_run = 0; done_seen = 1'b0; cyc = 0; cur_denom = 2'b00;
    while (!done_seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      bus.disp_ack = 1'b0;
      refill = 1'b0;
      if (done) begin
        done_seen = 1'b1;
        last_done_cyc = cyc;
      end else if (bus.disp_req) begin
        if (held == 0) begin
          check($sformatf("%s_coin%0d", tag, idx), bus.disp_denom,
                (idx < exp_n) ? exp_coins[idx] : 2'b00);
          check($sformatf("%s_gap%0d", tag, idx), low_run, (idx == 0) ? 0 : TB_GAP + 1);
          cur_denom = bus.disp_denom;
        end else begin
          check($sformatf("%s_hold%0d", tag, idx), bus.disp_denom, cur_denom);
        end
        if (held == ((idx == 0) ? delay0 : 0)) begin
          bus.disp_ack = 1'b1;
          if (idx == 0 && refill_at_ack) refill = 1'b1;
          idx++;
          held = 0;
        end else begin
          held++;
        end
        low_run = 0;
      end else begin
        check($sformatf("%s_reqdrop", tag), held, 0);
        check($sformatf("%s_denom0", tag), bus.disp_denom, 2'b00);
        low_run++;
      end
    end
    bus.disp_ack = 1'b0;
    refill = 1'b0;
    check($sformatf("%s_timeout", tag), done_seen, 1);
    check($sformatf("%s_ncoins", tag), idx, exp_n);
    check($sformatf("%s_shortfall", tag), shortfall, exp_sf);
    @(negedge clk);
    check($sformatf("%s_idle", tag), {done, busy, bus.amount_ready}, 3'b001);
    check($sformatf("%s_sf_held", tag), shortfall, exp_sf);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    refill = 1'b0;
    bus.amount_valid = 1'b0;
    bus.amount = 32'd0;
    bus.disp_ack = 1'b0;
    last_done_cyc = 0;
    #12;
    check("rst_outputs", {bus.amount_ready, bus.disp_req, bus.disp_denom, busy, done},
          6'b100000);
    check("rst_shortfall", shortfall, 0);
    @(negedge clk);
    reset = 1'b1;

    set_exp(5, D10, D10, D5, D1, D1);
    pay("p27", 32'd27, 0, 1'b0, 32'd0);
    pulse_refill();

    set_exp(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    pay("p0", 32'd0, 0, 1'b0, 32'd0);
    check("p0_latency", last_done_cyc, 1);

    set_exp(2, D10, D5, 2'b00, 2'b00, 2'b00);
    pay("p15", 32'd15, 4, 1'b0, 32'd0);
    pulse_refill();

    // acknowledge while idle must not start anything
    @(negedge clk);
    bus.disp_ack = 1'b1;
    @(negedge clk);
    bus.disp_ack = 1'b0;
    check("stray_ack", {busy, bus.disp_req, bus.amount_ready}, 3'b001);

`ifdef CHANGE_DISPENSER_STOCK_EN
    set_exp(1, D10, 2'b00, 2'b00, 2'b00, 2'b00);
    pay("p10", 32'd10, 0, 1'b0, 32'd0);
    set_exp(5, D10, D5, D5, D1, D1);
    pay("p25", 32'd25, 0, 1'b0, 32'd3);
    set_exp(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    pay("p3", 32'd3, 0, 1'b0, 32'd3);
    pulse_refill();
    set_exp(1, D10, 2'b00, 2'b00, 2'b00, 2'b00);
    pay("prefill", 32'd10, 0, 1'b1, 32'd0);
    set_exp(2, D10, D10, 2'b00, 2'b00, 2'b00);
    pay("p20", 32'd20, 0, 1'b0, 32'd0);
`else
    set_exp(3, D10, D10, D5, 2'b00, 2'b00);
    pay("p25", 32'd25, 0, 1'b0, 32'd0);
    set_exp(3, D1, D1, D1, 2'b00, 2'b00);
    pay("p3", 32'd3, 0, 1'b0, 32'd0);
    set_exp(1, D10, 2'b00, 2'b00, 2'b00, 2'b00);
    pay("prefill", 32'd10, 0, 1'b1, 32'd0);
    set_exp(2, D10, D10, 2'b00, 2'b00, 2'b00);
    pay("p20", 32'd20, 0, 1'b0, 32'd0);
`endif

    // reset while a request is outstanding
    @(negedge clk);
    bus.amount_valid = 1'b1;
    bus.amount = 32'd10;
    @(negedge clk);
    bus.amount_valid = 1'b0;
    n = 0;
    while (!bus.disp_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rstreq_seen", bus.disp_req, 1);
    reset = 1'b0;
    #1;
    check("rstreq_outputs", {bus.disp_req, bus.disp_denom, bus.amount_ready, busy, done},
          5'b00100);
    check("rstreq_shortfall", shortfall, 0);
    @(negedge clk);
    reset = 1'b1;

`ifdef CHANGE_DISPENSER_STOCK_EN
    set_exp(4, D10, D10, D5, D5, 2'b00);
`else
    set_exp(3, D10, D10, D10, 2'b00, 2'b00);
`endif
    pay("p30", 32'd30, 0, 1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
